pipe_credit_receiver: RTL and testbench

- Receive-side companion for fixed-latency, valid-only generated pipelines with no backpressure, such as the gate/assert pipelines.
- Admits upstream transactions into the pipeline only while it holds a credit, so every result has a reserved slot.
- Captures pipeline results into a local FIFO and presents them downstream on a valid/ready interface.
- Sits between a backpressured producer/consumer pair and the free-running pipeline instance.

---
 rtl/pipe_credit_receiver_if.sv | 28 ++
 rtl/pipe_credit_receiver.sv | 74 +++++++
 tb/tb_pipe_credit_receiver.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_credit_receiver_if.sv
// Handshake and pipeline-side signals of the credit receiver, grouped as one bundle.
// The slave view belongs to the receiver; the master view belongs to its environment.
interface pipe_credit_receiver_if #(
  parameter int WIDTH = 1
);
  logic             src_valid;
  logic             src_ready;
  logic             src_pred;
  logic [WIDTH-1:0] src_data;
  logic             pipe_in_valid;
  logic             pipe_in_pred;
  logic [WIDTH-1:0] pipe_in_data;
  logic             pipe_out_valid;
  logic [WIDTH-1:0] pipe_out_data;
  logic             dst_valid;
  logic             dst_ready;
  logic [WIDTH-1:0] dst_data;

  modport slave (
    input  src_valid, src_pred, src_data, pipe_out_valid, pipe_out_data, dst_ready,
    output src_ready, pipe_in_valid, pipe_in_pred, pipe_in_data, dst_valid, dst_data
  );

  modport master (
    output src_valid, src_pred, src_data, pipe_out_valid, pipe_out_data, dst_ready,
    input  src_ready, pipe_in_valid, pipe_in_pred, pipe_in_data, dst_valid, dst_data
  );
endinterface

// File: rtl/pipe_credit_receiver.sv
// Credit-gated front end and result FIFO for a fixed-latency pipeline with no backpressure.
// A transaction is only issued while a FIFO slot is reserved for its result.
module pipe_credit_receiver #(
  parameter int WIDTH   = 1,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4,
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipe_credit_receiver_if.slave bus,
  output logic                  overflow_err,
  output logic                  spurious_err,
  output logic [CW-1:0]         credits,
  output logic [CW-1:0]         inflight
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             issue;
  logic             pop;
  logic             full;
  logic             push;
  logic             recv_ok;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign bus.src_ready     = rst_n && (credits != '0);
  assign issue             = bus.src_valid && bus.src_ready;
  assign bus.pipe_in_valid = issue;
  assign bus.pipe_in_pred  = bus.src_pred;
  assign bus.pipe_in_data  = bus.src_data;

  assign full          = (count == CW'(DEPTH));
  assign bus.dst_valid = (count != '0);
  assign bus.dst_data  = mem[rd_ptr];
  assign pop           = bus.dst_valid && bus.dst_ready;

  // A same-cycle pop frees the head slot, so a full FIFO can still accept the result.
  assign push    = bus.pipe_out_valid && (!full || pop);
  assign recv_ok = bus.pipe_out_valid && (inflight != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits      <= CW'(DEPTH);
      inflight     <= '0;
      count        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      overflow_err <= 1'b0;
      spurious_err <= 1'b0;
    end else begin
      credits  <= credits - CW'(issue) + CW'(pop);
      inflight <= inflight + CW'(issue) - CW'(recv_ok);
      count    <= count + CW'(push) - CW'(pop);
      if (push) wr_ptr <= wrap_inc(wr_ptr);
      if (pop)  rd_ptr <= wrap_inc(rd_ptr);
      if (bus.pipe_out_valid && full && !pop) overflow_err <= 1'b1;
      if (bus.pipe_out_valid && (inflight == '0)) spurious_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.pipe_out_data;
  end

  // A fixed-latency pipeline can never hold more than LATENCY transactions.
  inflight_bound: assert property (@(posedge clk) disable iff (!rst_n) inflight <= CW'(LATENCY));
endmodule

// File: tb/tb_pipe_credit_receiver.sv
// Directed bench for pipe_credit_receiver with a two-stage valid-only pipeline model
// that can be overridden to inject spurious or overflowing results.
module tb_pipe_credit_receiver;
  localparam int WIDTH   = 1;
  localparam int LATENCY = 2;
  localparam int DEPTH   = 4;
  localparam int CW      = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          overflow_err;
  logic          spurious_err;
  logic [CW-1:0] credits;
  logic [CW-1:0] inflight;

  logic             stub_en = 1'b0;
  logic             stub_valid = 1'b0;
  logic [WIDTH-1:0] stub_data = '0;
  logic             v1, v2;
  logic [WIDTH-1:0] d1, d2;

  int checks = 0;
  int errors = 0;

  logic seq1 [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  int   cred1 [8] = '{4, 3, 2, 1, 1, 2, 3, 4};
  logic seq2 [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic seq3 [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic after3 [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic seq5 [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

  pipe_credit_receiver_if #(.WIDTH(WIDTH)) bus ();

  pipe_credit_receiver #(.WIDTH(WIDTH), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .overflow_err (overflow_err),
    .spurious_err (spurious_err),
    .credits      (credits),
    .inflight     (inflight)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0; v2 <= 1'b0; d1 <= '0; d2 <= '0;
    end else begin
      v1 <= bus.pipe_in_valid; d1 <= bus.pipe_in_data;
      v2 <= v1;                d2 <= d1;
    end
  end

  assign bus.pipe_out_valid = stub_en ? stub_valid : v2;
  assign bus.pipe_out_data  = stub_en ? stub_data  : d2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.src_valid = 1'b0; bus.dst_ready = 1'b0;
    stub_en = 1'b0; stub_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    bus.src_valid = 1'b0; bus.src_pred = 1'b0; bus.src_data = '0; bus.dst_ready = 1'b0;

    @(negedge clk);
    chk("rst_src_ready", bus.src_ready, 0);
    chk("rst_dst_valid", bus.dst_valid, 0);
    chk("rst_credits", credits, 4);
    chk("rst_inflight", inflight, 0);
    chk("rst_overflow", overflow_err, 0);
    chk("rst_spurious", spurious_err, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // back-to-back stream with free downstream
    bus.dst_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.src_valid = (k < 4);
      bus.src_data  = (k < 4) ? seq1[k] : 1'b0;
      bus.src_pred  = k[0];
      @(negedge clk);
      chk("t1_src_ready", bus.src_ready, 1);
      chk("t1_pipe_in_valid", bus.pipe_in_valid, (k < 4));
      chk("t1_pipe_in_pred", bus.pipe_in_pred, k[0]);
      chk("t1_credits", credits, cred1[k]);
      chk("t1_dst_valid", bus.dst_valid, (k >= 3 && k <= 6));
      if (k >= 3 && k <= 6) chk("t1_dst_data", bus.dst_data, seq1[k-3]);
      tick();
    end

    // downstream stalled, upstream always valid
    bus.dst_ready = 1'b0;
    bus.src_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.src_data = seq2[k % 4];
      @(negedge clk);
      chk("t2_src_ready", bus.src_ready, (k < 4));
      tick();
    end
    @(negedge clk);
    chk("t2_full_dst_valid", bus.dst_valid, 1);
    chk("t2_full_credits", credits, 0);
    chk("t2_full_inflight", inflight, 0);
    chk("t2_overflow", overflow_err, 0);
    chk("t2_spurious", spurious_err, 0);
    tick();
    bus.src_valid = 1'b0;
    bus.dst_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t2_pop_valid", bus.dst_valid, 1);
      chk("t2_pop_data", bus.dst_data, seq2[k]);
      tick();
    end
    @(negedge clk);
    chk("t2_empty", bus.dst_valid, 0);
    chk("t2_credits_back", credits, 4);
    tick();
    bus.src_valid = 1'b1;
    @(negedge clk);
    chk("t2_resume_ready", bus.src_ready, 1);
    chk("t2_resume_issue", bus.pipe_in_valid, 1);
    tick();
    bus.src_valid = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    chk("t2_drained_credits", credits, 4);
    tick();

    // full FIFO receiving while popping
    bus.dst_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.src_valid = 1'b1;
      bus.src_data  = seq3[k];
      tick();
    end
    bus.src_valid = 1'b0;
    repeat (4) tick();
    stub_en = 1'b1; stub_valid = 1'b1; stub_data = 1'b0;
    bus.dst_ready = 1'b1;
    @(negedge clk);
    chk("t3_full_credits", credits, 0);
    chk("t3_head_before", bus.dst_data, seq3[0]);
    tick();
    stub_valid = 1'b0;
    bus.dst_ready = 1'b0;
    @(negedge clk);
    chk("t3_no_overflow", overflow_err, 0);
    tick();
    bus.dst_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t3_pop_valid", bus.dst_valid, 1);
      chk("t3_pop_data", bus.dst_data, after3[k]);
      tick();
    end
    @(negedge clk);
    chk("t3_empty_after4", bus.dst_valid, 0);
    do_reset();

    // spurious result with nothing in flight
    stub_en = 1'b1; stub_valid = 1'b1; stub_data = 1'b1;
    @(negedge clk);
    chk("t4_spurious_before", spurious_err, 0);
    tick();
    stub_valid = 1'b0;
    @(negedge clk);
    chk("t4_spurious_set", spurious_err, 1);
    chk("t4_inflight_zero", inflight, 0);
    chk("t4_pushed_valid", bus.dst_valid, 1);
    chk("t4_pushed_data", bus.dst_data, 1);
    chk("t4_no_overflow", overflow_err, 0);
    tick();
    @(negedge clk);
    chk("t4_spurious_held", spurious_err, 1);
    do_reset();

    // overflow on a full, stalled FIFO
    for (int k = 0; k < 4; k++) begin
      bus.src_valid = 1'b1;
      bus.src_data  = seq5[k];
      tick();
    end
    bus.src_valid = 1'b0;
    repeat (4) tick();
    stub_en = 1'b1; stub_valid = 1'b1; stub_data = 1'b0;
    @(negedge clk);
    chk("t5_overflow_before", overflow_err, 0);
    tick();
    stub_valid = 1'b0;
    @(negedge clk);
    chk("t5_overflow_set", overflow_err, 1);
    chk("t5_head_unchanged", bus.dst_data, seq5[0]);
    chk("t5_credits", credits, 0);
    tick();
    stub_en = 1'b0;
    bus.dst_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t5_pop_data", bus.dst_data, seq5[k]);
      tick();
    end
    @(negedge clk);
    chk("t5_discarded", bus.dst_valid, 0);
    chk("t5_overflow_sticky", overflow_err, 1);
    tick();

    // reset with two in flight and two buffered
    bus.dst_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.src_valid = 1'b1;
      bus.src_data  = seq1[k];
      tick();
    end
    bus.src_valid = 1'b0;
    @(negedge clk);
    chk("t6_inflight", inflight, 2);
    chk("t6_buffered", bus.dst_valid, 1);
    chk("t6_credits", credits, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_dst_valid", bus.dst_valid, 0);
    chk("t6_rst_src_ready", bus.src_ready, 0);
    chk("t6_rst_credits", credits, 4);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_src_ready", bus.src_ready, 1);
    chk("t6_credits_after", credits, 4);
    chk("t6_inflight_after", inflight, 0);
    chk("t6_overflow_clr", overflow_err, 0);
    chk("t6_spurious_clr", spurious_err, 0);
    repeat (4) tick();
    @(negedge clk);
    chk("t6_no_stale", bus.dst_valid, 0);
    chk("t6_no_stale_err", spurious_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
